// File: rtl/modulator_symbol_mapper_if.sv
// AXI4-Stream style handshake bundle carrying 32-bit packed bits or {Q,I} samples.
interface modulator_symbol_mapper_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/modulator_symbol_mapper.sv
// Unpacks 32-bit stream words LSB-first into BPSK/QPSK/Gray-16QAM symbols and
// emits one {Q,I} sample per symbol, with a free-running handshake counter.
module modulator_symbol_mapper #(
    parameter logic signed [15:0] AMP_PSK  = 16'sh2D41,
    parameter logic signed [15:0] UNIT_QAM = 16'sh1000
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic                             cfg_enable,
    input  logic [1:0]                       cfg_mode,
    modulator_symbol_mapper_if.slave         s_axis,
    modulator_symbol_mapper_if.master        m_axis,
    output logic [31:0]                      sym_count
);

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_QAM16 = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam logic signed [15:0] QAM_OUTER = UNIT_QAM + UNIT_QAM + UNIT_QAM;

    function automatic logic [15:0] psk_level(input logic b);
        return b ? -AMP_PSK : AMP_PSK;
    endfunction

    function automatic logic [15:0] gray_level(input logic [1:0] b);
        case (b)
            2'b00:   return QAM_OUTER;
            2'b01:   return UNIT_QAM;
            2'b11:   return -UNIT_QAM;
            default: return -QAM_OUTER;
        endcase
    endfunction

    function automatic logic [31:0] map_symbol(input mode_e mode, input logic [3:0] bits);
        case (mode)
            MODE_QPSK:  return {psk_level(bits[1]), psk_level(bits[0])};
            MODE_QAM16: return {gray_level(bits[3:2]), gray_level(bits[1:0])};
            default:    return {16'h0000, psk_level(bits[0])};
        endcase
    endfunction

    function automatic logic [5:0] symbols_per_word(input mode_e mode);
        case (mode)
            MODE_QPSK:  return 6'd16;
            MODE_QAM16: return 6'd8;
            default:    return 6'd32;
        endcase
    endfunction

    // Holding register: a zero remaining count means empty.
    logic [31:0] shift_q;
    mode_e       mode_q;
    logic        last_q;
    logic [5:0]  remain_q;

    logic [31:0] out_data_q;
    logic        out_valid_q;
    logic        out_last_q;

    logic        holding;
    logic        last_sym;
    logic        load;
    logic        in_ready;
    logic        in_fire;
    logic [31:0] shift_next;

    assign holding  = (remain_q != 6'd0);
    assign last_sym = (remain_q == 6'd1);
    assign load     = (!out_valid_q || m_axis.tready) && holding;
    // Gating with ARESETN keeps tready low for the whole reset, even with cfg_enable high.
    assign in_ready = ARESETN && cfg_enable && (!holding || (last_sym && load));
    assign in_fire  = s_axis.tvalid && in_ready;

    // NOTE: shift_next gets a value on every path through the case, so no latch is inferred.
    always_comb begin
        case (mode_q)
            MODE_QPSK:  shift_next = shift_q >> 2;
            MODE_QAM16: shift_next = shift_q >> 4;
            default:    shift_next = shift_q >> 1;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            shift_q     <= '0;
            mode_q      <= MODE_BPSK;
            last_q      <= 1'b0;
            remain_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sym_count   <= '0;
        end else begin
            // A new word may land on the same edge the last symbol of the old one leaves.
            if (in_fire) begin
                shift_q  <= s_axis.tdata;
                mode_q   <= mode_e'(cfg_mode);
                last_q   <= s_axis.tlast;
                remain_q <= symbols_per_word(mode_e'(cfg_mode));
            end else if (load) begin
                shift_q  <= shift_next;
                remain_q <= remain_q - 6'd1;
            end

            if (load) begin
                out_data_q  <= map_symbol(mode_q, shift_q[3:0]);
                out_valid_q <= 1'b1;
                out_last_q  <= last_q && last_sym;
            end else if (m_axis.tready) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && m_axis.tready) begin
                sym_count <= sym_count + 32'd1;
            end
        end
    end

    assign s_axis.tready = in_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;

endmodule

// File: tb/tb_modulator_symbol_mapper.sv
// Self-checking bench: directed cases plus randomized words scored against a symbol-list model.
module tb_modulator_symbol_mapper;

    localparam int AMP = 'h2D41;
    localparam int UQ  = 'h1000;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } sample_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] sym_count;

    modulator_symbol_mapper_if s_if ();
    modulator_symbol_mapper_if m_if ();

    modulator_symbol_mapper dut (
        .ACLK       (clk),
        .ARESETN    (rst_n),
        .cfg_enable (cfg_enable),
        .cfg_mode   (cfg_mode),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    sample_t     exp_q[$];
    logic [31:0] obs_q[$];
    logic        obs_last_q[$];
    int          hs_count = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          ready_mode = 0;
    bit          en_rand = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          pat_idx = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Expected symbol list for one word, straight from the mapping tables.
    function automatic void model_word(input logic [31:0] word, input logic [1:0] mode, input logic last);
        int k;
        int n;
        int lvl[4];
        lvl = '{3, 1, -3, -1};
        k = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
        n = 32 / k;
        for (int i = 0; i < n; i++) begin
            int bits;
            int iv;
            int qv;
            sample_t s;
            bits = int'((word >> (i * k)) & ((32'd1 << k) - 32'd1));
            if (mode == 2'd2) begin
                iv = lvl[bits % 4] * UQ;
                qv = lvl[bits / 4] * UQ;
            end else if (mode == 2'd1) begin
                iv = (bits % 2 == 1) ? -AMP : AMP;
                qv = (bits / 2 == 1) ? -AMP : AMP;
            end else begin
                iv = (bits == 1) ? -AMP : AMP;
                qv = 0;
            end
            s.data = {qv[15:0], iv[15:0]};
            s.last = last && (i == n - 1);
            exp_q.push_back(s);
        end
    endfunction

    // Downstream ready driver: constant, 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                m_if.tready = pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end
            2:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = 1'b1;
        endcase
        cfg_enable = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output monitor: scores every handshake against the model queue.
    always @(negedge clk) begin
        if (rst_n) begin
            run_len = m_if.tvalid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (m_if.tvalid && m_if.tready) begin
                hs_count++;
                obs_q.push_back(m_if.tdata);
                obs_last_q.push_back(m_if.tlast);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", m_if.tdata, 32'hxxxxxxxx);
                end else begin
                    sample_t e;
                    e = exp_q.pop_front();
                    check("tdata", m_if.tdata, e.data);
                    check("tlast", 32'(m_if.tlast), 32'(e.last));
                end
            end
        end
    end

    // Offer one word; called and returns at posedge+1. Leaves tvalid high.
    task automatic offer(input logic [31:0] word, input logic [1:0] mode, input logic last, output int waits);
        bit got;
        got = 1'b0;
        waits = 0;
        cfg_mode = mode;
        s_if.tdata = word;
        s_if.tlast = last;
        s_if.tvalid = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            waits++;
            if (s_if.tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("input_accept_timeout", 32'd0, 32'd1);
        end else begin
            model_word(word, mode, last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !m_if.tvalid) break;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_m_tdata", m_if.tdata, 32'd0);
        check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        check("rst_sym_count", sym_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BPSK directed word
        obs_q.delete(); obs_last_q.delete();
        offer(32'h8000_0001, 2'd0, 1'b0, w);
        idle();
        drain();
        check("bpsk_count", 32'(obs_q.size()), 32'd32);
        check("bpsk_first", obs_q[0], 32'h0000D2BF);
        check("bpsk_mid", obs_q[15], 32'h00002D41);
        check("bpsk_last", obs_q[31], 32'h0000D2BF);
        check("bpsk_sym_count", sym_count, 32'd32);

        // QPSK directed word
        obs_q.delete(); obs_last_q.delete();
        offer(32'h0000_0006, 2'd1, 1'b0, w);
        idle();
        drain();
        check("qpsk_s0", obs_q[0], 32'hD2BF2D41);
        check("qpsk_s1", obs_q[1], 32'h2D41D2BF);
        check("qpsk_s15", obs_q[15], 32'h2D412D41);

        // 16QAM directed word with tlast
        obs_q.delete(); obs_last_q.delete();
        offer(32'h0000_00B4, 2'd2, 1'b1, w);
        idle();
        drain();
        check("qam_s0", obs_q[0], 32'h10003000);
        check("qam_s1", obs_q[1], 32'hD000F000);
        check("qam_s7", obs_q[7], 32'h30003000);
        check("qam_tlast6", 32'(obs_last_q[6]), 32'd0);
        check("qam_tlast7", 32'(obs_last_q[7]), 32'd1);

        // Back-to-back 16QAM words
        max_run = 0;
        offer(32'hA5C3_1E96, 2'd2, 1'b0, w);
        offer(32'h0F1E_2D3C, 2'd2, 1'b1, w);
        idle();
        check("b2b_ready_on_sym8", 32'(w), 32'd8);
        drain();
        check("b2b_valid_run", 32'(max_run), 32'd16);

        // Mode change while a 16QAM word drains
        obs_q.delete(); obs_last_q.delete();
        offer(32'h5A3C_96E1, 2'd2, 1'b0, w);
        idle();
        repeat (2) @(posedge clk);
        #1;
        cfg_mode = 2'd0;
        drain();
        check("mode_change_count", 32'(obs_q.size()), 32'd8);

        // Backpressure with 1,0,0,1 ready pattern
        ready_mode = 1;
        offer(32'h0000_0006, 2'd1, 1'b0, w);
        offer(32'h0000_00B4, 2'd2, 1'b1, w);
        offer($urandom, 2'd0, 1'b1, w);
        idle();
        drain();

        // Randomized words, ready and enable
        ready_mode = 2;
        en_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            offer($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        idle();
        en_rand = 1'b0;
        drain();
        check("sym_count_vs_handshakes", sym_count, 32'(hs_count));

        // Reset in the middle of a QPSK word
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        w = hs_count;
        offer(32'h1234_5678, 2'd1, 1'b0, w);
        idle();
        w = hs_count + 3;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (hs_count >= w) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("midrst_m_tdata", m_if.tdata, 32'd0);
        check("midrst_sym_count", sym_count, 32'd0);
        check("midrst_s_tready", 32'(s_if.tready), 32'd0);
        exp_q.delete();
        hs_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete(); obs_last_q.delete();
        offer(32'h0000_0006, 2'd1, 1'b0, w);
        idle();
        drain();
        check("post_rst_s0", obs_q[0], 32'hD2BF2D41);
        check("post_rst_s1", obs_q[1], 32'h2D41D2BF);
        check("post_rst_sym_count", sym_count, 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
